// File: rtl/rf_writeback_unit.sv
// Write-back stage feeding the register file's single write port.
// Merges a fixed-priority memory-load path with a valid/ready ALU path that
// is backed by a small holding FIFO, drops writes to R0, and flags pending
// writes against two read addresses for hazard detection.
//
// Handshake: an ALU write transfers on a rising Clk edge where
// Alu_Valid && Alu_Ready. Alu_Ready depends only on the current FIFO count,
// never on Alu_Valid. Once Alu_Valid is raised, the producer holds Alu_Awr and
// Alu_Data stable until the transfer. The memory path has no ready signal:
// every cycle with Mem_Valid=1 is one write.
module rf_writeback_unit #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int BUF_DEPTH = 2
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         Alu_Valid,
  output logic                         Alu_Ready,
  input  logic [ADDR_W-1:0]            Alu_Awr,
  input  logic [DATA_W-1:0]            Alu_Data,
  input  logic                         Mem_Valid,
  input  logic [ADDR_W-1:0]            Mem_Awr,
  input  logic [DATA_W-1:0]            Mem_Data,
  output logic [ADDR_W-1:0]            Awr,
  output logic [DATA_W-1:0]            Din,
  output logic                         WrEn,
  input  logic [ADDR_W-1:0]            Chk_Adr1,
  input  logic [ADDR_W-1:0]            Chk_Adr2,
  output logic                         Busy1,
  output logic                         Busy2,
  output logic [$clog2(BUF_DEPTH):0]   Buf_Count
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Holding FIFO storage and control
  logic [ADDR_W-1:0] buf_adr [BUF_DEPTH];
  logic [DATA_W-1:0] buf_dat [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic fifo_empty;
  logic alu_acc;
  logic alu_live;
  logic mem_live;
  logic push;
  logic pop;

  logic              sel_en;
  logic [ADDR_W-1:0] sel_adr;
  logic [DATA_W-1:0] sel_dat;

  assign fifo_empty = (count == '0);
  assign Alu_Ready  = (count < CNT_W'(BUF_DEPTH));
  assign alu_acc    = Alu_Valid && Alu_Ready;
  // R0 writes complete their handshake but carry no effect.
  assign alu_live   = alu_acc && (Alu_Awr != '0);
  assign mem_live   = Mem_Valid && (Mem_Awr != '0);
  // Buffered ALU writes drain only when memory is idle.
  assign pop        = !mem_live && !fifo_empty;
  // An ALU write goes to the FIFO whenever it cannot go straight out, which
  // keeps acceptance order and makes a same-cycle ALU write land after Mem.
  assign push       = alu_live && (mem_live || !fifo_empty);
  assign Buf_Count  = count;

  // Select the single write for the next edge: Mem, then FIFO head, then direct ALU
  always_comb begin
    sel_en  = 1'b0;
    sel_adr = Awr;
    sel_dat = Din;
    if (mem_live) begin
      sel_en  = 1'b1;
      sel_adr = Mem_Awr;
      sel_dat = Mem_Data;
    end else if (!fifo_empty) begin
      sel_en  = 1'b1;
      sel_adr = buf_adr[rd_ptr];
      sel_dat = buf_dat[rd_ptr];
    end else if (alu_live) begin
      sel_en  = 1'b1;
      sel_adr = Alu_Awr;
      sel_dat = Alu_Data;
    end
  end

  // Registered RF write port; address/data hold while no write is issued
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      WrEn <= 1'b0;
      Awr  <= '0;
      Din  <= '0;
    end else begin
      WrEn <= sel_en;
      if (sel_en) begin
        Awr <= sel_adr;
        Din <= sel_dat;
      end
    end
  end

  // FIFO payload storage; contents are meaningless outside the valid window
  always_ff @(posedge Clk) begin
    if (push) begin
      buf_adr[wr_ptr] <= Alu_Awr;
      buf_dat[wr_ptr] <= Alu_Data;
    end
  end

  // FIFO pointers wrap naturally at the power-of-two depth; push+pop keeps count
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Hazard flags: a read address is busy while any queued or issuing write targets it
  always_comb begin
    logic hit1;
    logic hit2;
    hit1 = WrEn && (Awr == Chk_Adr1);
    hit2 = WrEn && (Awr == Chk_Adr2);
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (CNT_W'(i) < count) begin
        if (buf_adr[rd_ptr + PTR_W'(i)] == Chk_Adr1) hit1 = 1'b1;
        if (buf_adr[rd_ptr + PTR_W'(i)] == Chk_Adr2) hit2 = 1'b1;
      end
    end
    Busy1 = hit1 && (Chk_Adr1 != '0);
    Busy2 = hit2 && (Chk_Adr2 != '0);
  end

endmodule
